// File: rtl/pbus_timer_if.sv
// rtl/pbus_timer_if.sv - peripheral bus request/response bundle for the timer
interface pbus_timer_if;
    logic [31:0] pbus_addr_i;
    logic [31:0] pbus_wdata_i;
    logic [3:0]  pbus_wstrb_i;
    logic        pbus_valid_i;
    logic        pbus_we_i;
    logic [31:0] pbus_rdata_o;
    logic        pbus_ready_o;

    modport master (
        output pbus_addr_i, pbus_wdata_i, pbus_wstrb_i, pbus_valid_i, pbus_we_i,
        input  pbus_rdata_o, pbus_ready_o
    );

    modport slave (
        input  pbus_addr_i, pbus_wdata_i, pbus_wstrb_i, pbus_valid_i, pbus_we_i,
        output pbus_rdata_o, pbus_ready_o
    );
endinterface

// File: rtl/pbus_timer.sv
// rtl/pbus_timer.sv - 64-bit prescaled timer with compare, auto-reload and match interrupt
module pbus_timer #(
    parameter int PRESC_W = 16,
    parameter int OFFS_W  = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pbus_timer_if.slave  bus,
    output logic         irq_o
);
    localparam int IDX_W = OFFS_W - 2;
    localparam logic [IDX_W-1:0] A_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] A_PRESC  = IDX_W'(1);
    localparam logic [IDX_W-1:0] A_CNT_LO = IDX_W'(2);
    localparam logic [IDX_W-1:0] A_CNT_HI = IDX_W'(3);
    localparam logic [IDX_W-1:0] A_CMP_LO = IDX_W'(4);
    localparam logic [IDX_W-1:0] A_CMP_HI = IDX_W'(5);
    localparam logic [IDX_W-1:0] A_STATUS = IDX_W'(6);

    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_nxt;

    logic               en, irq_en, auto_reload, match;
    logic [PRESC_W-1:0] presc, pcnt;
    logic [31:0]        count_lo, count_hi, cmp_lo, cmp_hi, shadow_hi;
    logic [31:0]        rdata_q, rd_mux, presc_merged;
    logic [63:0]        count, cmp;
    logic [IDX_W-1:0]   idx;
    logic               ready, wr_en, ctrl_wr, clr, presc_wr, cnt_lo_wr, cnt_hi_wr;
    logic               cmp_lo_wr, cmp_hi_wr, st_clr, tick, match_evt;
    logic               unused_ok;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return res;
    endfunction

    assign idx       = bus.pbus_addr_i[OFFS_W-1:2];
    assign count     = {count_hi, count_lo};
    assign cmp       = {cmp_hi, cmp_lo};
    assign unused_ok = &{1'b0, bus.pbus_addr_i[31:OFFS_W], bus.pbus_addr_i[1:0], presc_merged};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: if (bus.pbus_valid_i) state_nxt = RESP;
            RESP: begin
                ready     = bus.pbus_valid_i;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.pbus_ready_o = ready;
    assign bus.pbus_rdata_o = rdata_q;
    assign irq_o            = match & irq_en;

    // Writes land on the edge that closes RESP; an aborted request commits nothing.
    assign wr_en        = (state == RESP) && bus.pbus_valid_i && bus.pbus_we_i;
    assign ctrl_wr      = wr_en && (idx == A_CTRL) && bus.pbus_wstrb_i[0];
    assign clr          = ctrl_wr && bus.pbus_wdata_i[1];
    assign presc_wr     = wr_en && (idx == A_PRESC);
    assign cnt_lo_wr    = wr_en && (idx == A_CNT_LO);
    assign cnt_hi_wr    = wr_en && (idx == A_CNT_HI);
    assign cmp_lo_wr    = wr_en && (idx == A_CMP_LO);
    assign cmp_hi_wr    = wr_en && (idx == A_CMP_HI);
    assign st_clr       = wr_en && (idx == A_STATUS) && bus.pbus_wstrb_i[0] && bus.pbus_wdata_i[0];
    assign presc_merged = merge(32'(presc), bus.pbus_wdata_i, bus.pbus_wstrb_i);

    assign tick      = en && (pcnt == presc);
    assign match_evt = tick && (count == cmp);

    always_comb begin
        rd_mux = 32'd0;
        case (idx)
            A_CTRL:   rd_mux = {28'd0, auto_reload, irq_en, 1'b0, en};
            A_PRESC:  rd_mux = 32'(presc);
            A_CNT_LO: rd_mux = count_lo;
            A_CNT_HI: rd_mux = shadow_hi;
            A_CMP_LO: rd_mux = cmp_lo;
            A_CMP_HI: rd_mux = cmp_hi;
            A_STATUS: rd_mux = {31'd0, match};
            default:  rd_mux = 32'd0;
        endcase
    end

    // Read data and the COUNT_HI shadow are captured together so a LO-then-HI pair is atomic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q   <= 32'd0;
            shadow_hi <= 32'd0;
        end else if (state == IDLE && bus.pbus_valid_i) begin
            rdata_q <= bus.pbus_we_i ? 32'd0 : rd_mux;
            if (!bus.pbus_we_i && idx == A_CNT_LO) shadow_hi <= count_hi;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en          <= 1'b0;
            irq_en      <= 1'b0;
            auto_reload <= 1'b0;
            presc       <= '0;
            cmp_lo      <= 32'd0;
            cmp_hi      <= 32'd0;
        end else begin
            if (ctrl_wr) begin
                en          <= bus.pbus_wdata_i[0];
                irq_en      <= bus.pbus_wdata_i[2];
                auto_reload <= bus.pbus_wdata_i[3];
            end
            if (presc_wr)  presc  <= presc_merged[PRESC_W-1:0];
            if (cmp_lo_wr) cmp_lo <= merge(cmp_lo, bus.pbus_wdata_i, bus.pbus_wstrb_i);
            if (cmp_hi_wr) cmp_hi <= merge(cmp_hi, bus.pbus_wdata_i, bus.pbus_wstrb_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt     <= '0;
            count_lo <= 32'd0;
            count_hi <= 32'd0;
            match    <= 1'b0;
        end else begin
            if (clr || cnt_lo_wr || cnt_hi_wr || presc_wr) pcnt <= '0;
            else if (tick)                                 pcnt <= '0;
            else if (en)                                   pcnt <= pcnt + PRESC_W'(1);

            if (clr) begin
                count_lo <= 32'd0;
                count_hi <= 32'd0;
            end else if (cnt_lo_wr || cnt_hi_wr) begin
                if (cnt_lo_wr) count_lo <= merge(count_lo, bus.pbus_wdata_i, bus.pbus_wstrb_i);
                if (cnt_hi_wr) count_hi <= merge(count_hi, bus.pbus_wdata_i, bus.pbus_wstrb_i);
            end else if (tick) begin
                if (match_evt && auto_reload) {count_hi, count_lo} <= 64'd0;
                else                          {count_hi, count_lo} <= count + 64'd1;
            end

            if (match_evt)   match <= 1'b1;
            else if (st_clr) match <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pbus_timer.sv
// tb/tb_pbus_timer.sv - directed self-checking bench for pbus_timer
module tb_pbus_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    pbus_timer_if pif();

    pbus_timer #(.PRESC_W(16), .OFFS_W(12)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (pif),
        .irq_o (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One transaction; lat counts edges from request to ready, l_edge is the edge ready rose on.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rd, output int lat,
                        output int l_edge);
        @(posedge clk); #1;
        pif.pbus_addr_i  = addr;
        pif.pbus_wdata_i = wdata;
        pif.pbus_wstrb_i = strb;
        pif.pbus_we_i    = we;
        pif.pbus_valid_i = 1'b1;
        lat = 0;
        rd  = 32'd0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!pif.pbus_ready_o && lat < 8);
        rd     = pif.pbus_rdata_o;
        l_edge = cyc;
        @(posedge clk); #1;
        pif.pbus_valid_i = 1'b0;
        pif.pbus_we_i    = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, output int commit_edge);
        logic [31:0] d;
        int lat, le;
        xfer(1'b1, addr, data, 4'hF, d, lat, le);
        commit_edge = le + 1;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output int l_edge);
        int lat;
        xfer(1'b0, addr, 32'd0, 4'h0, data, lat, l_edge);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int lat, le;
        #1;
        checks++;
        if (pif.pbus_ready_o !== 1'b0 || irq !== 1'b0 || pif.pbus_rdata_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b irq=%b rdata=%h expected 0 0 0",
                     pif.pbus_ready_o, irq, pif.pbus_rdata_o);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int a = 0; a <= 'h18; a += 4) begin
            xfer(1'b0, 32'h2000_6000 + 32'(a), 32'd0, 4'h0, d, lat, le);
            checks++;
            if (d !== 32'd0 || lat !== 1) begin
                errors++;
                $display("FAIL reset_read_%0h rdata=%h lat=%0d expected 0 lat 1", a, d, lat);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq irq=%b expected 0", irq);
        end
    endtask

    task automatic test_prescale_match;
        logic [31:0] d;
        int e0, le;
        wr(32'h04, 32'd3, e0);
        wr(32'h10, 32'd5, e0);
        wr(32'h00, 32'h5, e0);
        repeat (23) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL presc_irq_early irq=%b expected 0 at EN+23", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL presc_irq_at_24 irq=%b expected 1", irq);
        end
        rd(32'h08, d, le);
        checks++;
        if (d !== 32'd6) begin
            errors++;
            $display("FAIL presc_count count=%0d expected 6", d);
        end
        rd(32'h18, d, le);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL presc_status status=%h expected 1", d);
        end
        wr(32'h00, 32'h2, e0);
        wr(32'h18, 32'h1, e0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL presc_irq_clear irq=%b expected 0", irq);
        end
    endtask

    task automatic test_auto_reload;
        logic [31:0] d;
        int e0, le;
        wr(32'h04, 32'd0, e0);
        wr(32'h10, 32'd2, e0);
        wr(32'h00, 32'h9, e0);
        for (int i = 0; i < 5; i++) begin
            rd(32'h08, d, le);
            checks++;
            if (d !== 32'((le - 1 - e0) % 3)) begin
                errors++;
                $display("FAIL reload_seq_%0d count=%0d expected %0d", i, d, (le - 1 - e0) % 3);
            end
        end
        rd(32'h18, d, le);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL reload_match status=%h expected 1", d);
        end
        wr(32'h00, 32'h2, e0);
        wr(32'h18, 32'h1, e0);
    endtask

    task automatic test_atomic_read;
        logic [31:0] lo, hi;
        logic [63:0] expv;
        int e0, le, le2;
        wr(32'h0C, 32'd0, e0);
        wr(32'h08, 32'hFFFF_FFF8, e0);
        wr(32'h00, 32'h1, e0);
        for (int i = 0; i < 4; i++) begin
            rd(32'h08, lo, le);
            rd(32'h0C, hi, le2);
            expv = 64'hFFFF_FFF8 + 64'(le - 1 - e0);
            checks++;
            if ({hi, lo} !== expv) begin
                errors++;
                $display("FAIL atomic_pair_%0d got=%h_%h expected %h", i, hi, lo, expv);
            end
        end
        checks++;
        if (hi !== 32'd1) begin
            errors++;
            $display("FAIL atomic_hi hi=%h expected 1", hi);
        end
        wr(32'h00, 32'h2, e0);
    endtask

    task automatic test_w1c_and_strobe;
        logic [31:0] d;
        int e0, lat, le;
        wr(32'h14, 32'd0, e0);
        wr(32'h10, 32'd0, e0);
        wr(32'h04, 32'd0, e0);
        wr(32'h00, 32'h9, e0);
        wr(32'h18, 32'h1, e0);
        rd(32'h18, d, le);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL w1c_vs_match status=%h expected 1", d);
        end
        wr(32'h00, 32'h0, e0);
        wr(32'h18, 32'h1, e0);
        rd(32'h18, d, le);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL w1c_clear status=%h expected 0", d);
        end
        xfer(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0010, d, lat, le);
        rd(32'h10, d, le);
        checks++;
        if (d !== 32'h0000_CC00) begin
            errors++;
            $display("FAIL strobe_cmp cmp_lo=%h expected 0000cc00", d);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_rdy;
        int e0;
        wr(32'h04, 32'hFFFF_1234, e0);
        @(posedge clk); #1;
        pif.pbus_addr_i  = 32'h04;
        pif.pbus_we_i    = 1'b0;
        pif.pbus_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp_rdy = (i % 2 == 0);
            checks++;
            if (pif.pbus_ready_o !== exp_rdy ||
                (exp_rdy && pif.pbus_rdata_o !== 32'h0000_1234)) begin
                errors++;
                $display("FAIL b2b_%0d ready=%b rdata=%h expected ready %b rdata 00001234",
                         i, pif.pbus_ready_o, pif.pbus_rdata_o, exp_rdy);
            end
        end
        pif.pbus_valid_i = 1'b0;
    endtask

    task automatic test_unmapped_and_reset;
        logic [31:0] d;
        int e0, lat, le;
        wr(32'h00, 32'h4, e0);
        xfer(1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, d, lat, le);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL unmapped_ack lat=%0d expected 1", lat);
        end
        rd(32'h40, d, le);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_read rdata=%h expected 0", d);
        end
        rd(32'h00, d, le);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL unmapped_side_effect ctrl=%h expected 4", d);
        end
        @(posedge clk); #1;
        pif.pbus_addr_i  = 32'h00;
        pif.pbus_wdata_i = 32'h5;
        pif.pbus_wstrb_i = 4'hF;
        pif.pbus_we_i    = 1'b1;
        pif.pbus_valid_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (pif.pbus_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready ready=%b expected 0", pif.pbus_ready_o);
        end
        @(posedge clk); #1;
        pif.pbus_valid_i = 1'b0;
        pif.pbus_we_i    = 1'b0;
        @(negedge clk) rst = 1'b0;
        rd(32'h00, d, le);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_ctrl ctrl=%h expected 0", d);
        end
    endtask

    initial begin
        pif.pbus_addr_i  = 32'd0;
        pif.pbus_wdata_i = 32'd0;
        pif.pbus_wstrb_i = 4'h0;
        pif.pbus_we_i    = 1'b0;
        pif.pbus_valid_i = 1'b0;
        test_reset();
        test_prescale_match();
        test_auto_reload();
        test_atomic_read();
        test_w1c_and_strobe();
        test_back_to_back();
        test_unmapped_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
